// File: rtl/ahb_default_slave_pkg.sv
// -----------------------------------------------------------------------------
// ahb_default_slave_pkg
// Shared AHB types for the default slave: transfer type, response type and
// the default-slave FSM state encoding, plus a small transfer-type helper.
// No ports (package).
// -----------------------------------------------------------------------------
package ahb_default_slave_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_type;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } defslv_state_e;

    // NONSEQ and SEQ are the only transfer types that carry a real access.
    function automatic logic is_active_trans(input htrans_type trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave_if.sv
// -----------------------------------------------------------------------------
// ahb_default_slave_if
// AHB slave-port bundle between the interconnect and the default slave.
//   hsel      : default-slave select (from the decoder)
//   haddr     : address-phase address
//   htrans    : transfer type
//   hwrite    : address-phase direction
//   hready    : bus ready (end of previous data phase)
//   hreadyout : slave ready
//   hresp     : slave response
//   hrdata    : slave read data
// Modports: master (interconnect side), slave (default slave side).
// -----------------------------------------------------------------------------
interface ahb_default_slave_if
    import ahb_default_slave_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    htrans_type        htrans;
    logic              hwrite;
    logic              hready;
    logic              hreadyout;
    hresp_type         hresp;
    logic [DATA_W-1:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hready,
        output hreadyout, hresp, hrdata
    );

endinterface

// File: rtl/ahb_default_slave.sv
// -----------------------------------------------------------------------------
// ahb_default_slave
// Responder for undecoded AHB transfers. Any accepted NONSEQ/SEQ transfer gets
// the two-cycle ERROR response; IDLE/BUSY get zero-wait OKAY. The address and
// direction of the latest errored transfer are logged and errors are counted
// (saturating).
//
// Ports:
//   hclk_i      : clock, rising edge
//   hreset_i    : synchronous active-high reset
//   bus         : ahb_default_slave_if.slave (hsel/haddr/htrans/hwrite/hready in,
//                 hreadyout/hresp/hrdata out; hrdata is always zero)
//   err_addr_o  : address of most recent errored transfer
//   err_write_o : hwrite of most recent errored transfer
//   err_count_o : saturating errored-transfer count
//   irq_o       : error interrupt
//   irq_clr_i   : interrupt clear
//
// Configuration macro: AHB_DEFSLV_IRQ_EN
//   defined   : irq_o is a sticky flop set on every accepted transfer and
//               cleared by irq_clr_i (a same-cycle set wins).
//   undefined : irq_o tied low, irq_clr_i ignored.
// -----------------------------------------------------------------------------
module ahb_default_slave
    import ahb_default_slave_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                      hclk_i,
    input  logic                      hreset_i,
    ahb_default_slave_if.slave        bus,
    output logic [AHB_ADDR_WIDTH-1:0] err_addr_o,
    output logic                      err_write_o,
    output logic [ERR_CNT_WIDTH-1:0]  err_count_o,
    output logic                      irq_o,
    input  logic                      irq_clr_i
);

    localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = ERR_CNT_WIDTH'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = {ERR_CNT_WIDTH{1'b1}};

    defslv_state_e             state_q, state_d;
    logic                      hreadyout_q, hreadyout_d;
    hresp_type                 hresp_q, hresp_d;
    logic [AHB_ADDR_WIDTH-1:0] err_addr_q;
    logic                      err_write_q;
    logic [ERR_CNT_WIDTH-1:0]  err_count_q;

    logic accept_s;
    logic log_en_s;

    assign accept_s = bus.hsel & bus.hready & is_active_trans(bus.htrans);
    // In ERR1 the bus hready is our own hreadyout (low), so nothing can be
    // accepted there; gating the log keeps it consistent with the FSM even if
    // the interconnect misdrives hready.
    assign log_en_s = accept_s & (state_q != DS_ERR1);

    // FSM state register.
    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            state_q <= DS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DS_IDLE: begin
                if (accept_s) begin
                    state_d = DS_ERR1;
                end else begin
                    state_d = DS_IDLE;
                end
            end
            DS_ERR1: begin
                state_d = DS_ERR2;
            end
            DS_ERR2: begin
                if (accept_s) begin
                    state_d = DS_ERR1;
                end else begin
                    state_d = DS_IDLE;
                end
            end
            default: begin
                state_d = DS_IDLE;
            end
        endcase
    end

    // FSM output decode, computed from the next state so the outputs can be
    // registered and still line up with the state they describe.
    always_comb begin
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        case (state_d)
            DS_IDLE: begin
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_OKAY;
            end
            DS_ERR1: begin
                hreadyout_d = 1'b0;
                hresp_d     = HRESP_ERROR;
            end
            DS_ERR2: begin
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_ERROR;
            end
            default: begin
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_OKAY;
            end
        endcase
    end

    // Registered bus response.
    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Error log: last offending address/direction and saturating count.
    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            err_addr_q  <= {AHB_ADDR_WIDTH{1'b0}};
            err_write_q <= 1'b0;
            err_count_q <= {ERR_CNT_WIDTH{1'b0}};
        end else if (log_en_s) begin
            err_addr_q  <= bus.haddr;
            err_write_q <= bus.hwrite;
            if (err_count_q != CNT_MAX) begin
                err_count_q <= err_count_q + CNT_ONE;
            end else begin
                err_count_q <= err_count_q;
            end
        end else begin
            err_addr_q  <= err_addr_q;
            err_write_q <= err_write_q;
            err_count_q <= err_count_q;
        end
    end

`ifdef AHB_DEFSLV_IRQ_EN
    logic irq_q, irq_d;

    // Sticky interrupt: a new error takes priority over a same-cycle clear.
    always_comb begin
        if (log_en_s) begin
            irq_d = 1'b1;
        end else if (irq_clr_i) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // Interrupt register.
    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    logic irq_clr_unused_s;

    assign irq_clr_unused_s = irq_clr_i;
    assign irq_o            = 1'b0;
`endif

    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;
    assign bus.hrdata    = {AHB_DATA_WIDTH{1'b0}};
    assign err_addr_o    = err_addr_q;
    assign err_write_o   = err_write_q;
    assign err_count_o   = err_count_q;

endmodule
